order_gen: RTL and testbench



---
 rtl/order_gen.sv | 215 +++++++++++++++++++++
 tb/tb_order_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_gen.sv
// order_gen: debounced key press -> pseudo-random buy/sell order -> small queue -> valid/ready.
// Optional build macro ORDER_AUTOGEN_EN adds a periodic automatic order source (AUTO_PERIOD).
module order_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned PRICE_W         = 8,
    parameter int unsigned QTY_W           = 4,
    parameter int unsigned ID_W            = 8,
    parameter int unsigned QDEPTH          = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
`ifdef ORDER_AUTOGEN_EN
    ,
    parameter int unsigned AUTO_PERIOD     = 1000
`endif
) (
    input  logic                      CLOCK_50,
    input  logic                      Reset,
    input  logic                      key_n,
    output logic                      order_valid,
    input  logic                      order_ready,
    output logic                      order_side,
    output logic [PRICE_W-1:0]        order_price,
    output logic [QTY_W-1:0]          order_qty,
    output logic [ID_W-1:0]           order_id,
    output logic                      key_held,
    output logic [$clog2(QDEPTH):0]   pending,
    output logic [7:0]                drop_cnt
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned AW    = $clog2(QDEPTH);
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         sync_q;
    logic               key_s;
    logic               press_pulse;
    logic               push_req;
    logic [15:0]        lfsr;

    logic               side_q  [QDEPTH];
    logic [PRICE_W-1:0] price_q [QDEPTH];
    logic [QTY_W-1:0]   qty_q   [QDEPTH];
    logic [ID_W-1:0]    id_q    [QDEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic [ID_W-1:0]    id_cnt;

    logic               do_push, do_pop, full;
    logic               new_side;
    logic [PRICE_W-1:0] new_price;
    logic [QTY_W-1:0]   new_qty;

    assign key_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous key; idles high (released)
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], key_n};
    end

    // Debounce state and stability counter
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Debounce next state; counter restarts on every state change
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (key_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Debounce outputs: single press pulse on acceptance, held level
    always_comb begin
        press_pulse = 1'b0;
        key_held    = 1'b0;
        if (state == PRESS_WAIT && !key_s && cnt == CNT_W'(DEBOUNCE_CYCLES - 1))
            press_pulse = 1'b1;
        if (state == HELD || state == RELEASE_WAIT)
            key_held = 1'b1;
    end

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, recovers from the all-zero lockup state
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset)              lfsr <= LFSR_SEED;
        else if (lfsr == 16'd0) lfsr <= LFSR_SEED;
        else                    lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

`ifdef ORDER_AUTOGEN_EN
    localparam int unsigned AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_pend, auto_fire, auto_req;

    assign auto_fire = (auto_cnt == AUTO_W'(AUTO_PERIOD - 1));
    assign auto_req  = auto_fire || auto_pend;
    assign push_req  = press_pulse || auto_req;

    // Periodic order source; an auto order colliding with a key press is deferred one cycle
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            auto_cnt  <= '0;
            auto_pend <= 1'b0;
        end else begin
            auto_cnt  <= auto_fire ? '0 : auto_cnt + AUTO_W'(1);
            auto_pend <= press_pulse && auto_req;
        end
    end
`else
    assign push_req = press_pulse;
`endif

    // Order fields from the current LFSR value; zero price/qty forced to 1
    always_comb begin
        new_side  = lfsr[0];
        new_price = lfsr[PRICE_W:1];
        new_qty   = lfsr[PRICE_W+QTY_W:PRICE_W+1];
        if (new_price == '0) new_price = PRICE_W'(1);
        if (new_qty == '0)   new_qty   = QTY_W'(1);
    end

    assign full        = (count == CW'(QDEPTH));
    assign order_valid = (count != '0);
    assign do_pop      = order_valid && order_ready;
    assign do_push     = push_req && (!full || do_pop);

    assign order_side  = side_q[rd_ptr];
    assign order_price = price_q[rd_ptr];
    assign order_qty   = qty_q[rd_ptr];
    assign order_id    = id_q[rd_ptr];
    assign pending     = count;

    // Order queue, id sequencing and saturating drop counter
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            id_cnt   <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                side_q[i]  <= 1'b0;
                price_q[i] <= '0;
                qty_q[i]   <= '0;
                id_q[i]    <= '0;
            end
        end else begin
            if (do_push) begin
                side_q[wr_ptr]  <= new_side;
                price_q[wr_ptr] <= new_price;
                qty_q[wr_ptr]   <= new_qty;
                id_q[wr_ptr]    <= id_cnt;
                wr_ptr          <= wr_ptr + AW'(1);
                id_cnt          <= id_cnt + ID_W'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
            if (push_req && !do_push && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_order_gen.sv
// Self-checking bench for order_gen with a short debounce window and a scoreboard of expected orders.
module tb_order_gen;

    localparam int unsigned DEB  = 4;
    localparam int unsigned PW   = 8;
    localparam int unsigned QW   = 4;
    localparam int unsigned IW   = 8;
    localparam int unsigned QD   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic          side;
        logic [PW-1:0] price;
        logic [QW-1:0] qty;
        logic [IW-1:0] id;
    } ord_t;

    logic                  clk = 1'b0;
    logic                  Reset = 1'b1;
    logic                  key_n = 1'b1;
    logic                  order_ready = 1'b0;
    logic                  order_valid;
    logic                  order_side;
    logic [PW-1:0]         order_price;
    logic [QW-1:0]         order_qty;
    logic [IW-1:0]         order_id;
    logic                  key_held;
    logic [$clog2(QD):0]   pending;
    logic [7:0]            drop_cnt;

    int   total = 0;
    int   bad   = 0;
    ord_t exp_q[$];
    ord_t mon_h;
    ord_t first_ord;
    logic [15:0] m_lfsr;
    logic [IW-1:0] m_id = '0;
    int   m_drop = 0;

    order_gen #(.DEBOUNCE_CYCLES(DEB), .PRICE_W(PW), .QTY_W(QW), .ID_W(IW),
                .QDEPTH(QD), .LFSR_SEED(SEED)) dut (
        .CLOCK_50   (clk),
        .Reset      (Reset),
        .key_n      (key_n),
        .order_valid(order_valid),
        .order_ready(order_ready),
        .order_side (order_side),
        .order_price(order_price),
        .order_qty  (order_qty),
        .order_id   (order_id),
        .key_held   (key_held),
        .pending    (pending),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11, shifting every cycle from the seed
    always @(posedge clk or posedge Reset) begin
        if (Reset)              m_lfsr <= SEED;
        else if (m_lfsr == 0)   m_lfsr <= SEED;
        else                    m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    function automatic ord_t form(input logic [15:0] r, input logic [IW-1:0] id);
        ord_t o;
        o.side  = r[0];
        o.price = r[PW:1];
        o.qty   = r[PW+QW:PW+1];
        if (o.price == 0) o.price = 1;
        if (o.qty == 0)   o.qty   = 1;
        o.id    = id;
        return o;
    endfunction

    // Scoreboard: every accepted handshake must match the oldest expected order
    always @(negedge clk) begin
        if (!Reset && order_valid && order_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got id=%0d, required no order", order_id);
            end else begin
                mon_h = exp_q.pop_front();
                if ({order_side, order_price, order_qty, order_id} !== mon_h) begin
                    bad++;
                    $display("FAIL pop_order: got side=%0d price=%0d qty=%0d id=%0d, required side=%0d price=%0d qty=%0d id=%0d",
                             order_side, order_price, order_qty, order_id,
                             mon_h.side, mon_h.price, mon_h.qty, mon_h.id);
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        Reset = 1'b1; key_n = 1'b1; order_ready = 1'b0;
        exp_q.delete(); m_id = '0; m_drop = 0;
        repeat (5) @(negedge clk);
        Reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One debounced press; predicts the order at the pulse cycle and queues it if it fits
    task automatic press(input bit rdy_pulse, input bit chk_lat, output ord_t got);
        ord_t e;
        @(negedge clk);
        key_n = 1'b0;
        repeat (5) @(negedge clk);
        if (rdy_pulse) begin
            @(posedge clk); #1; order_ready = 1'b1;
        end
        @(negedge clk);
        if (chk_lat) begin
            total++;
            if (order_valid !== 1'b0 || key_held !== 1'b0) begin
                bad++;
                $display("FAIL lat_pulse_cycle: got valid=%0d held=%0d, required valid=0 held=0", order_valid, key_held);
            end
        end
        #1;
        e = form(m_lfsr, m_id);
        if (exp_q.size() < QD) begin
            exp_q.push_back(e);
            m_id = m_id + 1'b1;
        end else if (m_drop < 255) begin
            m_drop++;
        end
        @(posedge clk); #1;
        if (rdy_pulse) order_ready = 1'b0;
        @(negedge clk);
        got = {order_side, order_price, order_qty, order_id};
        if (chk_lat) begin
            total++;
            if (order_valid !== 1'b1 || key_held !== 1'b1 || order_id !== e.id ||
                order_price == 0 || order_qty == 0) begin
                bad++;
                $display("FAIL lat_valid: got valid=%0d held=%0d id=%0d price=%0d qty=%0d, required valid=1 held=1 id=%0d nonzero fields",
                         order_valid, key_held, order_id, order_price, order_qty, e.id);
            end
        end
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
        if (chk_lat) begin
            total++;
            if (key_held !== 1'b0) begin
                bad++;
                $display("FAIL release: got held=%0d, required 0", key_held);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk); #1; order_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1; order_ready = 1'b0;
        @(negedge clk);
        total++;
        if (exp_q.size() != 0 || order_valid !== 1'b0 || pending !== 0) begin
            bad++;
            $display("FAIL drain: got left=%0d valid=%0d pending=%0d, required 0 0 0", exp_q.size(), order_valid, pending);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        Reset = 1'b1; key_n = 1'b1; order_ready = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (order_valid !== 0 || order_side !== 0 || order_price !== 0 || order_qty !== 0 ||
            order_id !== 0 || key_held !== 0 || pending !== 0 || drop_cnt !== 0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%0d s=%0d p=%0d q=%0d id=%0d h=%0d pend=%0d drop=%0d, required all 0",
                     order_valid, order_side, order_price, order_qty, order_id, key_held, pending, drop_cnt);
        end
        Reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_press();
        ord_t got;
        press(1'b0, 1'b1, got);
        first_ord = got;
        total++;
        if (got.id !== 0 || pending !== 1) begin
            bad++;
            $display("FAIL clean_press: got id=%0d pending=%0d, required id=0 pending=1", got.id, pending);
        end
        drain();
    endtask

    task automatic test_bounce();
        bit held_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) begin
                @(negedge clk);
                if (key_held) held_seen = 1'b1;
            end
        end
        key_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (key_held) held_seen = 1'b1;
        end
        total++;
        if (held_seen || order_valid !== 0 || pending !== 0 || drop_cnt !== 0) begin
            bad++;
            $display("FAIL bounce: got held_seen=%0d valid=%0d pending=%0d drop=%0d, required all 0",
                     held_seen, order_valid, pending, drop_cnt);
        end
    endtask

    task automatic test_backpressure();
        ord_t got;
        apply_reset();
        for (int i = 0; i < 6; i++) press(1'b0, 1'b0, got);
        total++;
        if (pending !== 4 || drop_cnt !== 2 || drop_cnt !== 8'(m_drop)) begin
            bad++;
            $display("FAIL bp_counts: got pending=%0d drop=%0d, required pending=4 drop=2", pending, drop_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (order_valid !== 1'b1 || {order_side, order_price, order_qty, order_id} !== exp_q[0] || order_id !== 0) begin
                bad++;
                $display("FAIL bp_stall_hold: got v=%0d id=%0d price=%0d, required v=1 id=0 price=%0d",
                         order_valid, order_id, order_price, exp_q[0].price);
            end
        end
        drain();
        press(1'b0, 1'b0, got);
        total++;
        if (got.id !== 4) begin
            bad++;
            $display("FAIL bp_next_id: got id=%0d, required 4", got.id);
        end
        drain();
    endtask

    task automatic test_full_pop();
        ord_t got;
        apply_reset();
        for (int i = 0; i < 4; i++) press(1'b0, 1'b0, got);
        press(1'b1, 1'b0, got);
        total++;
        if (pending !== 4 || drop_cnt !== 0) begin
            bad++;
            $display("FAIL full_pop: got pending=%0d drop=%0d, required pending=4 drop=0", pending, drop_cnt);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        ord_t got;
        for (int i = 0; i < 3; i++) press(1'b0, 1'b0, got);
        total++;
        if (pending !== 3) begin
            bad++;
            $display("FAIL mid_pending: got %0d, required 3", pending);
        end
        @(negedge clk);
        Reset = 1'b1;
        exp_q.delete(); m_id = '0; m_drop = 0;
        #1;
        total++;
        if (order_valid !== 0 || pending !== 0) begin
            bad++;
            $display("FAIL mid_reset_clear: got valid=%0d pending=%0d, required 0 0", order_valid, pending);
        end
        repeat (5) @(negedge clk);
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        press(1'b0, 1'b1, got);
        total++;
        if (got !== first_ord || got.id !== 0) begin
            bad++;
            $display("FAIL mid_reset_replay: got side=%0d price=%0d qty=%0d id=%0d, required side=%0d price=%0d qty=%0d id=0",
                     got.side, got.price, got.qty, got.id, first_ord.side, first_ord.price, first_ord.qty);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_backpressure();
        test_full_pop();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
